enigma_uart_tx: RTL and testbench

ENIGMA_UART_TX -- requirements
Module: enigma_uart_tx

---
 rtl/enigma_pkg.sv | 23 ++
 rtl/enigma_tx_fifo.sv | 65 ++++++
 rtl/enigma_uart_tx.sv | 185 ++++++++++++++++++
 tb/tb_enigma_uart_tx.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// enigma_pkg -- shared definitions for the Enigma UART transmit path.
//   tx_state_e      : transmitter FSM states
//   UART_DATA_BITS  : data bits per UART frame
//   UART_IDLE_LEVEL : serial line level while idle / during stop bit
//   even_parity()   : XOR of the data bits (used when ENIGMA_TX_PARITY_EN is defined)
package enigma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int unsigned UART_DATA_BITS  = 8;
  localparam logic        UART_IDLE_LEVEL = 1'b1;

  function automatic logic even_parity(input logic [UART_DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/enigma_tx_fifo.sv
// enigma_tx_fifo -- synchronous FIFO buffering ciphertext bytes for the UART.
// Ports:
//   clk_i   : clock (rising edge)
//   rst_i   : asynchronous active-high reset, empties the FIFO
//   push_i  : write data_i this cycle (ignored when full unless popping too)
//   data_i  : byte to write
//   pop_i   : consume the head entry this cycle (ignored when empty)
//   data_o  : head entry (valid when empty_o is low)
//   full_o  : DEPTH entries held
//   empty_o : no entries held
// Pointers carry one extra wrap bit so full and empty can be told apart
// when the index bits match. Reads are not bypassed: a byte written into an
// empty FIFO becomes visible on data_o the cycle after it is written.
module enigma_tx_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign empty_o = (wptr_q == rptr_q);
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign data_o  = mem_q[rptr_q[AW-1:0]];

  // A full FIFO may still accept a byte when the head leaves on the same edge.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (do_push) wptr_d = wptr_q + PTR_ONE;
    if (do_pop)  rptr_d = rptr_q + PTR_ONE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/enigma_uart_tx.sv
// enigma_uart_tx -- buffered UART transmitter for Enigma ciphertext bytes.
// Parameters:
//   CLKS_PER_BIT : clock cycles per UART bit (2..65535)
//   FIFO_DEPTH   : byte buffer depth (power of two, 2..64)
// Ports:
//   i_clock    : clock (rising edge)
//   reset      : asynchronous active-high reset; aborts any frame in flight
//   i_data     : encoded ASCII byte
//   i_valid    : offers i_data this cycle
//   o_tx       : serial line, idle high (registered)
//   o_busy     : frame on the line or bytes buffered (registered)
//   o_full     : buffer holds FIFO_DEPTH bytes
//   o_overflow : sticky, a byte was dropped because the buffer was full
// Build option: define ENIGMA_TX_PARITY_EN to append an even-parity bit
// (8E1, 11-bit frame); otherwise frames are 8N1.
module enigma_uart_tx
  import enigma_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned FIFO_DEPTH   = 8
) (
  input  logic       i_clock,
  input  logic       reset,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_full,
  output logic       o_overflow
);

  localparam logic [15:0] CNT_RELOAD = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT   = 3'(UART_DATA_BITS - 1);

  tx_state_e   state_q;
  logic [15:0] cnt_q;
  logic [2:0]  bit_q;
  logic [7:0]  shift_q;
  logic        tx_q;
  logic        busy_q;
  logic        ovf_q;
`ifdef ENIGMA_TX_PARITY_EN
  logic        parity_q;
`endif

  logic       fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [7:0] fifo_rdata;
  logic       bit_end;
  logic       line_d;

  enigma_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk_i   (i_clock),
    .rst_i   (reset),
    .push_i  (fifo_push),
    .data_i  (i_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign bit_end = (cnt_q == '0);

  // Loading from STOP as well as IDLE lets frames run back to back.
  always_comb begin
    fifo_pop = 1'b0;
    if (!fifo_empty) begin
      if (state_q == ST_IDLE)              fifo_pop = 1'b1;
      if (state_q == ST_STOP && bit_end)   fifo_pop = 1'b1;
    end
  end

  assign fifo_push = i_valid && (!fifo_full || fifo_pop);

  // Line level for the current state; registered into tx_q, so the line
  // trails the FSM by one cycle.
  always_comb begin
    line_d = UART_IDLE_LEVEL;
    unique case (state_q)
      ST_IDLE:   line_d = UART_IDLE_LEVEL;
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_q[0];
`ifdef ENIGMA_TX_PARITY_EN
      ST_PARITY: line_d = parity_q;
`else
      ST_PARITY: line_d = UART_IDLE_LEVEL;
`endif
      ST_STOP:   line_d = UART_IDLE_LEVEL;
      default:   line_d = UART_IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge i_clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      tx_q     <= UART_IDLE_LEVEL;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef ENIGMA_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      tx_q   <= line_d;
      busy_q <= (state_q != ST_IDLE) || !fifo_empty;
      if (i_valid && fifo_full && !fifo_pop) ovf_q <= 1'b1;

      unique case (state_q)
        ST_IDLE: begin
          if (fifo_pop) begin
            shift_q  <= fifo_rdata;
`ifdef ENIGMA_TX_PARITY_EN
            parity_q <= even_parity(fifo_rdata);
`endif
            cnt_q    <= CNT_RELOAD;
            state_q  <= ST_START;
          end
        end
        ST_START: begin
          if (bit_end) begin
            cnt_q   <= CNT_RELOAD;
            bit_q   <= '0;
            state_q <= ST_DATA;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            cnt_q <= CNT_RELOAD;
            if (bit_q == LAST_BIT) begin
`ifdef ENIGMA_TX_PARITY_EN
              state_q <= ST_PARITY;
`else
              state_q <= ST_STOP;
`endif
            end else begin
              shift_q <= shift_q >> 1;
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_PARITY: begin
          if (bit_end) begin
            cnt_q   <= CNT_RELOAD;
            state_q <= ST_STOP;
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              shift_q  <= fifo_rdata;
`ifdef ENIGMA_TX_PARITY_EN
              parity_q <= even_parity(fifo_rdata);
`endif
              cnt_q    <= CNT_RELOAD;
              state_q  <= ST_START;
            end else begin
              cnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end else begin
            cnt_q <= cnt_q - 16'd1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_tx       = tx_q;
  assign o_busy     = busy_q;
  assign o_full     = fifo_full;
  assign o_overflow = ovf_q;

endmodule

// File: tb/tb_enigma_uart_tx.sv
// tb_enigma_uart_tx -- directed self-checking bench for enigma_uart_tx
// (CLKS_PER_BIT=4, FIFO_DEPTH=8). Honours ENIGMA_TX_PARITY_EN for frame length.
module tb_enigma_uart_tx;

  localparam int unsigned CPB   = 4;
  localparam int unsigned DEPTH = 8;
`ifdef ENIGMA_TX_PARITY_EN
  localparam int unsigned NB = 11;
`else
  localparam int unsigned NB = 10;
`endif
  localparam int unsigned FR = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       o_tx, o_busy, o_full, o_overflow;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  enigma_uart_tx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .i_clock    (clk),
    .reset      (rst),
    .i_data     (data),
    .i_valid    (valid),
    .o_tx       (o_tx),
    .o_busy     (o_busy),
    .o_full     (o_full),
    .o_overflow (o_overflow)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // UART receiver: samples each bit at its centre and queues received bytes.
  logic [7:0]  rx_q[$];
  int          rx_ferr = 0;
  logic        mon_active = 1'b0;
  int          mon_k = 0;
  logic [10:0] mon_bits = '0;

  always @(negedge clk) begin
    if (rst) begin
      mon_active <= 1'b0;
      mon_k      <= 0;
    end else if (!mon_active) begin
      if (o_tx == 1'b0) begin
        mon_active <= 1'b1;
        mon_k      <= 1;
      end
    end else begin
      mon_k <= mon_k + 1;
      if ((mon_k % CPB) == (CPB / 2)) begin
        mon_bits[mon_k / CPB] <= o_tx;
        if (mon_k / CPB == 0 && o_tx !== 1'b0) rx_ferr <= rx_ferr + 1;
        if (mon_k / CPB == NB - 1) begin
          mon_active <= 1'b0;
          if (o_tx !== 1'b1) rx_ferr <= rx_ferr + 1;
`ifdef ENIGMA_TX_PARITY_EN
          if (mon_bits[9] !== ^mon_bits[8:1]) rx_ferr <= rx_ferr + 1;
`endif
          rx_q.push_back(mon_bits[8:1]);
        end
      end
    end
  end

  // Expected line samples, one per cycle, LSB = first cycle of the start bit.
  function automatic logic [127:0] frame_bits(input logic [7:0] d);
    logic [10:0]  f;
    logic [127:0] r;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = d;
`ifdef ENIGMA_TX_PARITY_EN
    f[9]   = ^d;
`endif
    r = '0;
    for (int i = 0; i < FR; i++) r[i] = f[i / CPB];
    return r;
  endfunction

  task automatic send(input logic [7:0] d);
    valid = 1'b1;
    data  = d;
    @(negedge clk);
    valid = 1'b0;
  endtask

  task automatic capture(input int n, output logic [127:0] v, output logic busy_last);
    v = '0;
    busy_last = 1'b0;
    for (int i = 0; i < n; i++) begin
      v[i]      = o_tx;
      busy_last = o_busy;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle(input string tag, input int limit);
    int i;
    i = 0;
    repeat (3) @(negedge clk);
    while (o_busy && i < limit) begin
      @(negedge clk);
      i++;
    end
    check(tag, o_busy, 1'b0);
  endtask

  initial begin
    logic [127:0] v;
    logic         bl;

    // Reset state
    #1 rst = 1'b1;
    @(negedge clk);
    check("rst_tx", o_tx, 1'b1);
    check("rst_busy", o_busy, 1'b0);
    check("rst_full", o_full, 1'b0);
    check("rst_ovf", o_overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single byte 0x41: start bit two edges after the push edge
    send(8'h41);
    @(negedge clk);
    check("lat_tx_high", o_tx, 1'b1);
    check("busy_rise", o_busy, 1'b1);
    @(negedge clk);
    capture(FR, v, bl);
    check("frame_41", v, frame_bits(8'h41));
    check("busy_last_bit", bl, 1'b1);
    check("busy_fall", o_busy, 1'b0);
    check("tx_idle", o_tx, 1'b1);
    rx_q.delete();
    repeat (2) @(negedge clk);

    // Back-to-back frames 0x5A, 0x7A with no idle gap
    send(8'h5A);
    send(8'h7A);
    @(negedge clk);
    capture(2 * FR, v, bl);
    check("b2b_frames", v, (frame_bits(8'h7A) << FR) | frame_bits(8'h5A));
    check("b2b_busy_fall", o_busy, 1'b0);
    rx_q.delete();
    repeat (2) @(negedge clk);

    // Full FIFO accepts a push on the edge the stop bit pops the next byte
    for (int i = 0; i < 9; i++) send(8'h60 + 8'(i));
    repeat (FR + 1 - 9) @(negedge clk);
    check("full_pre_pop", o_full, 1'b1);
    send(8'h69);
    check("ovf_pop_push", o_overflow, 1'b0);
    check("full_post_pop", o_full, 1'b1);
    wait_idle("idle_pop_push", 12 * FR);
    check("rx_cnt_pop_push", rx_q.size(), 10);
    for (int i = 0; i < 10 && i < rx_q.size(); i++)
      check($sformatf("rx_pop_push_%0d", i), rx_q[i], 8'h60 + 8'(i));
    rx_q.delete();

    // Ten pushes while idle: one in flight, eight buffered, tenth dropped
    for (int i = 0; i < 10; i++) send(8'h30 + 8'(i));
    check("full_burst", o_full, 1'b1);
    check("ovf_burst", o_overflow, 1'b1);
    wait_idle("idle_burst", 11 * FR);
    check("rx_cnt_burst", rx_q.size(), 9);
    for (int i = 0; i < 9 && i < rx_q.size(); i++)
      check($sformatf("rx_burst_%0d", i), rx_q[i], 8'h30 + 8'(i));
    check("ovf_sticky", o_overflow, 1'b1);
    rx_q.delete();

    // Reset during the third data bit of 0x41 with 0x55 buffered
    send(8'h41);
    send(8'h55);
    repeat (14) @(negedge clk);
    check("pre_rst_bit2", o_tx, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_tx", o_tx, 1'b1);
    check("midrst_busy", o_busy, 1'b0);
    check("midrst_full", o_full, 1'b0);
    check("midrst_ovf", o_overflow, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    rx_q.delete();
    repeat (2) @(negedge clk);
    send(8'h42);
    @(negedge clk);
    check("post_rst_lat", o_tx, 1'b1);
    @(negedge clk);
    capture(FR, v, bl);
    check("frame_42", v, frame_bits(8'h42));
    check("post_rst_busy_fall", o_busy, 1'b0);
    check("rx_cnt_post_rst", rx_q.size(), 1);
    if (rx_q.size() > 0) check("rx_post_rst", rx_q[0], 8'h42);
    check("framing_errors", rx_ferr, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

endmodule
